coin_bar_scan: RTL and testbench

COIN_BAR_SCAN -- requirements
Module: coin_bar_scan

---
 rtl/coin_pkg.sv | 23 ++
 rtl/therm_enc.sv | 20 ++
 rtl/coin_bar_scan.sv | 237 +++++++++++++++++++++++
 tb/tb_coin_bar_scan.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin channel bar scanner.
// Holds the dispense FSM state type, default parameter values and the
// channel-index width helper used by coin_bar_scan and its sub-module.
package coin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_HOLD = 2'd2
    } disp_state_e;

    localparam int N_CH_DEF      = 4;
    localparam int CW_DEF        = 4;
    localparam int BAR_W_DEF     = 9;
    localparam int SCAN_DIV_DEF  = 50_000_000;
    localparam int BLINK_DIV_DEF = 12_500_000;

    // Index width for n items: clog2(n), never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/therm_enc.sv
// Count-to-thermometer encoder: lights the lowest min(cnt, BAR_W) bits and
// flags counts that exceed the bar length.
module therm_enc #(
    parameter int CW    = 4,
    parameter int BAR_W = 9
) (
    input  logic [CW-1:0]    cnt,
    output logic [BAR_W-1:0] therm,
    output logic             ovf
);

    // Bit i is lit when the count exceeds i, which saturates naturally at BAR_W.
    always_comb begin
        for (int i = 0; i < BAR_W; i++) begin
            therm[i] = (32'(cnt) > 32'(i));
        end
        ovf = (32'(cnt) > 32'(BAR_W));
    end

endmodule

// File: rtl/coin_bar_scan.sv
// Coin channel counters with a single-coin dispense handshake and a
// thermometer bar that shows one channel at a time (auto scan or manual).
// Optional build macro COIN_BAR_BLINK_EN: the overflowing bar blinks instead
// of staying all-ones.
module coin_bar_scan
    import coin_pkg::*;
#(
    parameter int  N_CH      = N_CH_DEF,
    parameter int  CW        = CW_DEF,
    parameter int  BAR_W     = BAR_W_DEF,
    parameter int  SCAN_DIV  = SCAN_DIV_DEF,
    parameter int  BLINK_DIV = BLINK_DIV_DEF,
    localparam int SW        = ch_idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    input  logic [SW-1:0]    ld_ch,
    input  logic [CW-1:0]    ld_cnt,
    input  logic             disp_req,
    input  logic [SW-1:0]    disp_ch,
    output logic             disp_ack,
    output logic             disp_empty,
    input  logic             sel_mode,
    input  logic [SW-1:0]    sel_ch,
    output logic [BAR_W-1:0] bar,
    output logic [N_CH-1:0]  bar_ch,
    output logic             ovf
);

    localparam int SCW = ch_idx_w(SCAN_DIV);

    // Dividers shorter than one clock make no sense; stop elaboration.
    if (SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_div
        $error("coin_bar_scan: SCAN_DIV and BLINK_DIV must be at least 1");
    end

    logic [CW-1:0]    cnt_q [N_CH];
    logic [CW-1:0]    cnt_d [N_CH];
    disp_state_e      state_q, state_d;
    logic             ack_q, ack_d, empty_q, empty_d;
    logic             dec_en_s;
    logic [SCW-1:0]   scan_q, scan_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [BAR_W-1:0] bar_q, bar_d;
    logic [N_CH-1:0]  bar_ch_q, bar_ch_d;
    logic             ovf_q, ovf_d;
    logic             ld_ok_s, disp_ok_s, show_ok_s;
    logic [CW-1:0]    show_cnt_s;
    logic [BAR_W-1:0] therm_s;
    logic             therm_ovf_s;
    logic             blank_s;

    // Channel indices only need range checks when N_CH is not a power of two.
    if (N_CH == (1 << SW)) begin : g_full_idx
        assign ld_ok_s   = 1'b1;
        assign disp_ok_s = 1'b1;
        assign show_ok_s = 1'b1;
    end else begin : g_part_idx
        assign ld_ok_s   = (32'(ld_ch) < 32'(N_CH));
        assign disp_ok_s = (32'(disp_ch) < 32'(N_CH));
        assign show_ok_s = (32'(sel_d) < 32'(N_CH));
    end

    // Dispense FSM: decide once per request in DEC, then wait for release in HOLD.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        empty_d  = 1'b0;
        dec_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (disp_req) begin
                    state_d = ST_DEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEC: begin
                if (!disp_ok_s) begin
                    empty_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (ld_valid && ld_ok_s && (ld_ch == disp_ch)) begin
                    // A load to the same channel wins; decide again on the new value.
                    state_d = ST_DEC;
                end else if (cnt_q[disp_ch] != {CW{1'b0}}) begin
                    dec_en_s = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    empty_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!disp_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Count update: a load overrides, otherwise an accepted dispense decrements.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (ld_valid && ld_ok_s && (32'(ld_ch) == 32'(i))) begin
                cnt_d[i] = ld_cnt;
            end else if (dec_en_s && (32'(disp_ch) == 32'(i))) begin
                cnt_d[i] = cnt_q[i] - CW'(1'b1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Displayed channel: follows sel_ch in manual mode, steps every SCAN_DIV clocks in auto.
    always_comb begin
        if (sel_mode) begin
            sel_d  = sel_ch;
            scan_d = {SCW{1'b0}};
        end else if (scan_q == SCW'(SCAN_DIV - 1)) begin
            scan_d = {SCW{1'b0}};
            if (32'(sel_q) >= 32'(N_CH - 1)) begin
                sel_d = {SW{1'b0}};
            end else begin
                sel_d = sel_q + SW'(1'b1);
            end
        end else begin
            scan_d = scan_q + SCW'(1'b1);
            sel_d  = sel_q;
        end
    end

    assign show_cnt_s = show_ok_s ? cnt_q[sel_d] : {CW{1'b0}};

    therm_enc #(
        .CW    (CW),
        .BAR_W (BAR_W)
    ) u_therm_enc (
        .cnt   (show_cnt_s),
        .therm (therm_s),
        .ovf   (therm_ovf_s)
    );

`ifdef COIN_BAR_BLINK_EN
    localparam int BCW = ch_idx_w(BLINK_DIV);
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blank_q, blank_d;

    // Blink phase runs only while the shown count overflows; each overflow starts lit.
    always_comb begin
        if (ovf_d) begin
            if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
                blink_cnt_d = {BCW{1'b0}};
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BCW'(1'b1);
                blank_d     = blank_q;
            end
        end else begin
            blink_cnt_d = {BCW{1'b0}};
            blank_d     = 1'b0;
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= {BCW{1'b0}};
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign blank_s = blank_q;
`else
    assign blank_s = 1'b0;
`endif

    // Next bar, one-hot channel and overflow flag for the channel about to be shown.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            bar_ch_d[i] = show_ok_s && (32'(sel_d) == 32'(i));
        end
        ovf_d = show_ok_s && therm_ovf_s;
        if (!show_ok_s) begin
            bar_d = {BAR_W{1'b0}};
        end else if (therm_ovf_s) begin
            bar_d = blank_s ? {BAR_W{1'b0}} : {BAR_W{1'b1}};
        end else begin
            bar_d = therm_s;
        end
    end

    // State, counts and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            empty_q  <= 1'b0;
            scan_q   <= {SCW{1'b0}};
            sel_q    <= {SW{1'b0}};
            bar_q    <= {BAR_W{1'b0}};
            bar_ch_q <= N_CH'(1'b1);
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q  <= state_d;
            ack_q    <= ack_d;
            empty_q  <= empty_d;
            scan_q   <= scan_d;
            sel_q    <= sel_d;
            bar_q    <= bar_d;
            bar_ch_q <= bar_ch_d;
            ovf_q    <= ovf_d;
        end
    end

    assign disp_ack   = ack_q;
    assign disp_empty = empty_q;
    assign bar        = bar_q;
    assign bar_ch     = bar_ch_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_coin_bar_scan.sv
// Directed bench for coin_bar_scan with a cycle-level reference model and
// hand-computed spot checks.
module tb_coin_bar_scan;

    localparam int N_CH      = 4;
    localparam int CW        = 4;
    localparam int BAR_W     = 9;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 3;
    localparam int SW        = 2;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             ld_valid = 1'b0;
    logic [SW-1:0]    ld_ch    = 2'd0;
    logic [CW-1:0]    ld_cnt   = 4'd0;
    logic             disp_req = 1'b0;
    logic [SW-1:0]    disp_ch  = 2'd0;
    logic             sel_mode = 1'b1;
    logic [SW-1:0]    sel_ch   = 2'd0;
    logic             disp_ack, disp_empty, ovf;
    logic [BAR_W-1:0] bar;
    logic [N_CH-1:0]  bar_ch;

    always #5 clk = ~clk;

    coin_bar_scan #(
        .N_CH      (N_CH),
        .CW        (CW),
        .BAR_W     (BAR_W),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_ch      (ld_ch),
        .ld_cnt     (ld_cnt),
        .disp_req   (disp_req),
        .disp_ch    (disp_ch),
        .disp_ack   (disp_ack),
        .disp_empty (disp_empty),
        .sel_mode   (sel_mode),
        .sel_ch     (sel_ch),
        .bar        (bar),
        .bar_ch     (bar_ch),
        .ovf        (ovf)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_ack  = 0;
    int n_emp  = 0;

    // Reference model state: plain counts, shown channel, request bookkeeping.
    int               m_cnt [N_CH];
    int               m_disp, m_tick, m_run;
    bit               m_pend, m_wait_rel;
    logic [BAR_W-1:0] m_bar;
    logic [N_CH-1:0]  m_bar_ch;
    logic             m_ovf, m_ack, m_empty;

    task automatic m_reset();
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        m_disp = 0; m_tick = 0; m_run = 0;
        m_pend = 1'b0; m_wait_rel = 1'b0;
        m_bar = '0; m_bar_ch = 4'b0001; m_ovf = 1'b0;
        m_ack = 1'b0; m_empty = 1'b0;
    endtask

    task automatic m_step();
        int c, s, dc;
        // Display uses the counts as they were before this edge.
        if (sel_mode) begin
            m_disp = int'(sel_ch);
            m_tick = 0;
        end else begin
            m_tick++;
            if (m_tick == SCAN_DIV) begin
                m_tick = 0;
                m_disp = (m_disp + 1) % N_CH;
            end
        end
        c        = m_cnt[m_disp];
        s        = (c > BAR_W) ? BAR_W : c;
        m_bar    = BAR_W'((1 << s) - 1);
        m_ovf    = (c > BAR_W);
        m_bar_ch = N_CH'(1 << m_disp);
        if (m_ovf) m_run++;
        else m_run = 0;
`ifdef COIN_BAR_BLINK_EN
        if (m_ovf && ((((m_run - 1) / BLINK_DIV) % 2) == 1)) m_bar = '0;
`endif
        // One decision per request, taken the edge after it was seen.
        m_ack   = 1'b0;
        m_empty = 1'b0;
        dc      = int'(disp_ch);
        if (m_pend) begin
            if (ld_valid && (ld_ch == disp_ch)) begin
                m_pend = 1'b1;
            end else if (m_cnt[dc] > 0) begin
                m_cnt[dc]--;
                m_ack = 1'b1; m_pend = 1'b0; m_wait_rel = 1'b1;
            end else begin
                m_empty = 1'b1; m_pend = 1'b0; m_wait_rel = 1'b1;
            end
        end else if (m_wait_rel) begin
            if (!disp_req) m_wait_rel = 1'b0;
        end else if (disp_req) begin
            m_pend = 1'b1;
        end
        if (ld_valid) m_cnt[int'(ld_ch)] = int'(ld_cnt);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_vec++;
            if (bar !== m_bar || bar_ch !== m_bar_ch || ovf !== m_ovf ||
                disp_ack !== m_ack || disp_empty !== m_empty) begin
                n_miss++;
                $display("FAIL model t=%0t got bar=%b ch=%b ovf=%b ack=%b emp=%b want bar=%b ch=%b ovf=%b ack=%b emp=%b",
                         $time, bar, bar_ch, ovf, disp_ack, disp_empty,
                         m_bar, m_bar_ch, m_ovf, m_ack, m_empty);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_count(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (disp_ack === 1'b1) n_ack++;
            if (disp_empty === 1'b1) n_emp++;
        end
    endtask

    task automatic load(input logic [SW-1:0] ch, input logic [CW-1:0] v);
        ld_valid = 1'b1; ld_ch = ch; ld_cnt = v;
        step(1);
        ld_valid = 1'b0;
    endtask

    logic [BAR_W-1:0] exp_bar [4];
    logic [N_CH-1:0]  exp_ch;

    initial begin
        exp_bar = '{9'b000000011, 9'b000000001, 9'b000000000, 9'b000000000};
        step(3);
        chk("rst_bar", 32'(bar), 32'(9'b0));
        chk("rst_bar_ch", 32'(bar_ch), 32'(4'b0001));
        chk("rst_ovf", 32'(ovf), 32'(1'b0));
        chk("rst_ack", 32'(disp_ack), 32'(1'b0));
        chk("rst_empty", 32'(disp_empty), 32'(1'b0));
        rst_n = 1'b1;

        // Manual display of a loaded channel.
        sel_mode = 1'b1; sel_ch = 2'd1;
        load(2'd1, 4'd5);
        step(1);
        chk("ld_bar", 32'(bar), 32'(9'b000011111));
        chk("ld_bar_ch", 32'(bar_ch), 32'(4'b0010));
        chk("ld_ovf", 32'(ovf), 32'(1'b0));

        // Held request on an empty channel gives exactly one empty pulse.
        sel_ch = 2'd2;
        load(2'd2, 4'd0);
        disp_ch = 2'd2; disp_req = 1'b1;
        n_ack = 0; n_emp = 0;
        step_count(6);
        chk("empty_pulses", 32'(n_emp), 32'd1);
        chk("empty_acks", 32'(n_ack), 32'd0);
        disp_req = 1'b0;
        step(2);
        chk("empty_bar", 32'(bar), 32'(9'b0));

        // Three dispenses drain ch0, the fourth is refused.
        sel_ch = 2'd0;
        load(2'd0, 4'd3);
        step(1);
        chk("ch0_bar", 32'(bar), 32'(9'b000000111));
        n_ack = 0; n_emp = 0;
        disp_ch = 2'd0;
        for (int k = 0; k < 4; k++) begin
            disp_req = 1'b1;
            step_count(3);
            disp_req = 1'b0;
            step_count(2);
            chk("drain_bar", 32'(bar), 32'(exp_bar[k]));
        end
        chk("drain_acks", 32'(n_ack), 32'd3);
        chk("drain_empties", 32'(n_emp), 32'd1);

        // Load colliding with the decision cycle wins and delays the ack.
        sel_ch = 2'd3;
        load(2'd3, 4'd2);
        disp_ch = 2'd3; disp_req = 1'b1;
        step(1);
        ld_valid = 1'b1; ld_ch = 2'd3; ld_cnt = 4'd7;
        step(1);
        ld_valid = 1'b0;
        chk("coll_no_ack", 32'(disp_ack), 32'(1'b0));
        chk("coll_no_empty", 32'(disp_empty), 32'(1'b0));
        step(1);
        chk("coll_ack", 32'(disp_ack), 32'(1'b1));
        disp_req = 1'b0;
        step(2);
        chk("coll_bar", 32'(bar), 32'(9'b000111111));

        // Overflowing count.
        sel_ch = 2'd1;
        load(2'd1, 4'd12);
        step(2);
        chk("ovf_flag", 32'(ovf), 32'(1'b1));
`ifndef COIN_BAR_BLINK_EN
        chk("ovf_bar", 32'(bar), 32'(9'h1FF));
        step(4);
        chk("ovf_bar_steady", 32'(bar), 32'(9'h1FF));
`endif

        // Auto scan from ch0, stepping every SCAN_DIV clocks and wrapping.
        sel_ch = 2'd0;
        step(2);
        sel_mode = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_ch = 4'b0001 << ((k / 4) % 4);
            chk("scan_ch", 32'(bar_ch), 32'(exp_ch));
        end

        // Back to auto from manual ch2: full period before the first step.
        sel_mode = 1'b1; sel_ch = 2'd2;
        step(2);
        sel_mode = 1'b0;
        step(3);
        chk("resume_hold", 32'(bar_ch), 32'(4'b0100));
        step(1);
        chk("resume_step", 32'(bar_ch), 32'(4'b1000));

        // Reset in the middle of a dispense; held request is new afterwards.
        sel_mode = 1'b1; sel_ch = 2'd3;
        step(1);
        disp_ch = 2'd3; disp_req = 1'b1;
        step(1);
        rst_n = 1'b0;
        step(2);
        chk("mid_rst_ack", 32'(disp_ack), 32'(1'b0));
        chk("mid_rst_bar", 32'(bar), 32'(9'b0));
        chk("mid_rst_ch", 32'(bar_ch), 32'(4'b0001));
        rst_n = 1'b1;
        step(2);
        chk("post_rst_empty", 32'(disp_empty), 32'(1'b1));
        chk("post_rst_ack", 32'(disp_ack), 32'(1'b0));
        disp_req = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
